// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the two-port SRAM arbiter/controller.
// Default geometry, controller states and read-tag format live here.
package sram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH  = 4;
  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_WMASK_WIDTH = 2;
  localparam int NUM_PORTS       = 2;

  typedef enum logic {
    INIT,
    SERVE
  } state_e;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_id_t;

  // One stage of the read-response tag pipeline.
  typedef struct packed {
    logic     vld;
    port_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/sram_arb_ctrl_if.sv
// Request/response bus between the requesters (master) and the controller (slave).
// Per-port request fields are packed side by side, port 0 in the LSBs.
interface sram_arb_ctrl_if #(
  parameter int DATA_WIDTH  = sram_ctrl_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = sram_ctrl_pkg::DEF_ADDR_WIDTH,
  parameter int WMASK_WIDTH = sram_ctrl_pkg::DEF_WMASK_WIDTH
) ();

  localparam int NP = sram_ctrl_pkg::NUM_PORTS;

  logic [NP-1:0]             req_valid;
  logic [NP-1:0]             req_ready;
  logic [NP-1:0]             req_we;
  logic [NP*WMASK_WIDTH-1:0] req_wmask;
  logic [NP*ADDR_WIDTH-1:0]  req_addr;
  logic [NP*DATA_WIDTH-1:0]  req_wdata;
  logic [NP-1:0]             rsp_valid;
  logic [DATA_WIDTH-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_rr_arb.sv
// Two-way round-robin grant: the pointer names the preferred port,
// a lone requester is always granted. Purely combinational, one-hot output.
module sram_rr_arb
  import sram_ctrl_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid_i,
  input  port_id_t             ptr_i,
  output logic [NUM_PORTS-1:0] grant_o
);

  port_id_t other;

  assign other = ~ptr_i;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_o = '0;
    if (valid_i[ptr_i]) begin
      grant_o[ptr_i] = 1'b1;
    end else if (valid_i[other]) begin
      grant_o[other] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Clears the attached SRAM after reset, then arbitrates two request ports onto it
// with registered macro inputs and a two-stage read-tag pipeline for responses.
module sram_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  sram_arb_ctrl_if.slave         bus,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output logic                   init_done
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  port_id_t               ptr_q, ptr_d;
  logic                   init_done_q;
  logic                   we_q, we_d;
  logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  rd_tag_t                tag1_q, tag1_d, tag2_q;

  logic [NUM_PORTS-1:0]   arb_valid, grant;
  port_id_t               gnt_id;
  logic [WMASK_WIDTH-1:0] wmask_a [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign wmask_a[p] = bus.req_wmask[p*WMASK_WIDTH +: WMASK_WIDTH];
    assign addr_a[p]  = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[p] = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
  end

  // Requests are invisible to the arbiter while the memory is being cleared.
  assign arb_valid = (state_q == SERVE) ? bus.req_valid : '0;

  sram_rr_arb u_arb (
    .valid_i (arb_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign bus.req_ready = grant;
  assign gnt_id        = grant[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    tag1_d  = '0;
    case (state_q)
      INIT: begin
        we_d    = 1'b1;
        wmask_d = '1;
        din_d   = '0;
        addr_d  = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = SERVE;
      end
      SERVE: begin
        if (|grant) begin
          we_d       = bus.req_we[gnt_id];
          wmask_d    = wmask_a[gnt_id];
          addr_d     = addr_a[gnt_id];
          din_d      = wdata_a[gnt_id];
          ptr_d      = ~gnt_id;
          tag1_d.vld = ~bus.req_we[gnt_id];
          tag1_d.id  = gnt_id;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      we_q        <= 1'b0;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      init_done_q <= (state_q == SERVE);
      we_q        <= we_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
    end
  end

  assign sram_we    = we_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;
  assign init_done  = init_done_q;

  // The macro's read data arrives two cycles after the grant, aligned with tag2.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_valid[tag2_q.id] = tag2_q.vld;
  end
  assign bus.rsp_rdata = sram_dout;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: behavioural SRAM macro, directed stimulus with
// hand-computed expectations, and a queue-based response scoreboard.
module tb_sram_arb_ctrl;
  import sram_ctrl_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 6;
  localparam int MW    = 2;
  localparam int LW    = DW / MW;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sram_arb_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic          init_done;

  sram_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .init_done  (init_done)
  );

  // Synchronous-read SRAM macro with per-lane write mask.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    sram_dout <= mem[sram_addr];
    if (sram_we) begin
      for (int l = 0; l < MW; l++) begin
        if (sram_wmask[l]) mem[sram_addr][l*LW +: LW] <= sram_din[l*LW +: LW];
      end
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (bus.rsp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_port", 32'(bus.rsp_valid), 32'd1 << e.port);
        check("rsp_data", 32'(bus.rsp_rdata), 32'(e.data));
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_port(input int p, input logic we, input logic [MW-1:0] m,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[p]           = 1'b1;
    bus.req_we[p]              = we;
    bus.req_wmask[p*MW +: MW]  = m;
    bus.req_addr[p*AW +: AW]   = a;
    bus.req_wdata[p*DW +: DW]  = d;
  endtask

  // Single-port request: must be granted in its own cycle; reads queue a response.
  task automatic issue(input int p, input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_d, input string name);
    @(negedge clock);
    bus.req_valid = '0;
    set_port(p, we, m, a, d);
    #1;
    check(name, 32'(bus.req_ready), 32'd1 << p);
    if (!we) exp_q.push_back(exp_t'{p, exp_d, cyc + 2});
  endtask

  task automatic idle();
    @(negedge clock);
    bus.req_valid = '0;
  endtask

  // Walks the clearing sequence; requesters are kept asserting to prove they are ignored.
  task automatic init_check(input int stop_at);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clock);
      if (k == DEPTH - 1) bus.req_valid = '0;
      #1;
      check("init_wr", {init_done, bus.req_ready, sram_we, sram_wmask, sram_addr, sram_din},
            {1'b0, 2'b00, 1'b1, {MW{1'b1}}, AW'(k), {DW{1'b0}}});
      if (k == stop_at) return;
    end
    @(negedge clock);
    #1;
    check("init_done", {init_done, sram_we}, 2'b10);
  endtask

  task automatic check_reset(input string name);
    @(negedge clock);
    #1;
    check(name, {init_done, sram_we, sram_wmask, sram_addr, sram_din, bus.rsp_valid, bus.req_ready}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_wmask = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (2) @(negedge clock);
    check_reset("reset_state");
    reset_n = 1'b1;
    bus.req_valid = '1;

    // Reset in the middle of clearing restarts from address 0.
    init_check(20);
    reset_n = 1'b0;
    bus.req_valid = '0;
    check_reset("reset_mid_init");
    reset_n = 1'b1;
    bus.req_valid = '1;
    init_check(DEPTH);

    issue(0, 1'b0, 2'b00, 6'd5, 4'h0, 4'h0, "rd5_p0_ready");
    idle();
    issue(1, 1'b1, 2'b11, 6'd9, 4'hA, 4'h0, "wr9_p1_ready");
    issue(1, 1'b0, 2'b00, 6'd9, 4'h0, 4'hA, "rd9_p1_ready");
    idle();
    issue(1, 1'b1, 2'b01, 6'd3, 4'hF, 4'h0, "wr3_lo_ready");
    issue(1, 1'b0, 2'b00, 6'd3, 4'h0, 4'h3, "rd3_lo_ready");
    issue(0, 1'b1, 2'b10, 6'd3, 4'h4, 4'h0, "wr3_hi_ready");
    issue(0, 1'b0, 2'b00, 6'd3, 4'h0, 4'h7, "rd3_hi_ready");
    idle();

    // Pointer rests on port 0 after the last port-0 read? No: it moved to port 1,
    // so park one port-1 read first to bring it back to port 0.
    issue(1, 1'b0, 2'b00, 6'd9, 4'h0, 4'hA, "rd9_p1b_ready");
    idle();

    // Both ports contend for four cycles: grants alternate 0,1,0,1.
    @(negedge clock);
    set_port(0, 1'b0, 2'b00, 6'd9, 4'h0);
    set_port(1, 1'b0, 2'b00, 6'd3, 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      g = i % 2;
      check("rr_grant", 32'(bus.req_ready), 32'd1 << g);
      exp_q.push_back(exp_t'{g, (g == 1) ? 4'h7 : 4'hA, cyc + 2});
    end
    idle();

    // A read in flight when reset hits must never produce a response.
    @(negedge clock);
    bus.req_valid = '0;
    set_port(0, 1'b0, 2'b00, 6'd9, 4'h0);
    #1;
    check("rd_pre_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clock);
    bus.req_valid = '0;
    reset_n = 1'b0;
    check_reset("reset_mid_serve");
    reset_n = 1'b1;
    bus.req_valid = '1;
    init_check(DEPTH);

    issue(1, 1'b0, 2'b00, 6'd9, 4'h0, 4'h0, "rd9_cleared_ready");
    idle();
    repeat (4) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
